clk_pulse_gen: RTL and testbench
================================

# clk_pulse_gen

Multi-channel programmable clock-enable and pulse generator. Each channel divides the single system clock by a run-time period, producing:
- a duty-cycled level output, `pout`;
- a one-cycle `tick` at the start of each period.

It replaces single-channel fixed test-clock stubs. It sits beside the system clock as the enable source for slow peripherals and test stimulus.

## Interface
- `NCH`, 4: number of independent channels (1..16).
- `DIV_W`, 16: width of period, high-time and counter registers.
- `CH_W`, max(1, clog2(NCH)): width of `load_ch`.
- `DEF_DIV`, 10: reset period of every channel. Reset high time is `DEF_DIV>>1`.

Ports:
- `clk` input 1: single system clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `en` input NCH: per-channel run enable.
- `load` input 1: write period/high time to channel `load_ch` this cycle.
- `load_ch` input CH_W: target channel. Values >= NCH are ignored.
- `div_val` input DIV_W: new period P.
- `high_val` input DIV_W: new high time H, in cycles.
- `sync` input 1: phase-align all running channels.
- `pout` output NCH: per-channel divided level.
- `tick` output NCH: per-channel period-start pulse.

## Operation
- Per-channel registers:
  - P: period.
  - H: high time.
  - C: counter, 0..P-1.
  - run: active flag.
- Outputs are decoded from registers only; there is no input-to-output combinational path.
  - `pout[i]` = run & (C < H)
  - `tick[i]` = run & (C == 0)
- Per-channel update at each edge, in priority order:
  1. `rst_n`=0: P=DEF_DIV, H=DEF_DIV>>1, C=0, run=0.
  2. `load` & `load_ch`==i: P=`div_val`, H=`high_val`, C=0, run=0. This restarts the channel regardless of `en`/`sync`.
  3. `en[i]`=0 or P==0: C=0, run=0.
  4. run=0 (channel starting): run=1, C=0.
  5. `sync`=1: C=0 (run stays 1).
  6. Otherwise: C = (C==P-1) ? 0 : C+1.
- Channel states: IDLE (run=0) and RUN (run=1).
  - IDLE -> RUN: `en` high, P!=0, no load.
  - RUN -> IDLE: `en` low, P==0, load, or reset.
- Arithmetic:
  - Unsigned compare and increment at DIV_W bits.
  - C never exceeds P-1, because P changes only via load, which clears C.
  - Maximum period is 2^DIV_W-1 cycles.
- Boundary cases:
  - P=0: channel held IDLE; outputs 0 even with `en` high.
  - P=1: `tick` every cycle; `pout` constant 1 if H>=1, else 0.
  - H=0: `pout` always 0; `tick` still runs.
  - H>=P: `pout` constant 1 while running.
  - `load` with `load_ch`>=NCH: no channel changes.
  - `sync` does not start IDLE channels; `en` governs starting.

## Timing
- Reset: all `pout`=0 and `tick`=0 in the cycle after the reset edge. This also applies when reset is asserted mid-operation.
- Latency from `en[i]` sampled high, channel IDLE:
  - `tick[i]`=1 and `pout[i]`=(H>0) in the next cycle.
  - Period is exactly P cycles from then on.
- `en[i]` sampled low: outputs 0 in the next cycle. Re-enable restarts at C=0; there is no phase memory.
- Load latency:
  - Outputs are 0 in the cycle after the load edge.
  - With `en` held high, the first `tick` of the new period appears 2 cycles after the load edge.
- `sync` sampled high: every running channel shows `tick` in the next cycle, simultaneously.
- Simultaneous events on one channel resolve by the priority list above. Events on different channels are independent.

## Test plan
- Default and reset:
  - Stimulus: `rst_n`=0 for 3 cycles with `en`=4'hF, then release.
  - Required: outputs 0 during reset.
  - Required: first `tick` 1 cycle after the release edge, then every 10 cycles.
  - Required: `pout` high for 5 cycles, low for 5.
  - Stimulus: drop `rst_n` mid-period.
  - Required: all outputs 0 in the next cycle.
- Load:
  - Stimulus: load ch1 with P=4, H=1, `en` high.
  - Required: outputs 0 for 1 cycle, then `pout[1]` pattern 1,0,0,0 repeating, with `tick[1]` coincident with each 1.
  - Required: other channels are undisturbed.
- Edge periods:
  - P=1, H=1: `tick`=`pout`=1 every cycle.
  - P=0 with `en` high: both outputs held 0.
  - P=5, H=0: `pout`=0, `tick` every 5 cycles.
  - P=5, H=7: `pout` constant 1.
- Sync:
  - Stimulus: ch0 P=6 and ch2 P=6 running with a 3-cycle phase offset; pulse `sync` once.
  - Required: both `tick` in the same cycle 1 cycle later, and aligned thereafter.
- Enable and priority:
  - Stimulus: drop `en[3]` mid-period, then re-raise.
  - Required: `tick[3]` 1 cycle after re-raise.
  - Stimulus: `load` ch3 and `sync` in the same cycle.
  - Required: ch3 goes IDLE, not aligned.
- Out-of-range load:
  - Stimulus: NCH=3, `load_ch`=3.
  - Required: no channel's P, H or outputs change.

Source files
------------

// File: rtl/clk_pulse_gen.sv
// Multi-channel programmable clock-enable / pulse generator.
// Each channel divides the system clock by a run-time period and emits a duty-cycled level plus a period-start tick.
module clk_pulse_gen #(
   parameter int NCH     = 4,
   parameter int DIV_W   = 16,
   parameter int CH_W    = (NCH > 1) ? $clog2(NCH) : 1,
   parameter int DEF_DIV = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   en,
   input  logic             load,
   input  logic [CH_W-1:0]  load_ch,
   input  logic [DIV_W-1:0] div_val,
   input  logic [DIV_W-1:0] high_val,
   input  logic             sync,
   output logic [NCH-1:0]   pout,
   output logic [NCH-1:0]   tick
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chState_e;

   logic [DIV_W-1:0] period_q [NCH];
   logic [DIV_W-1:0] period_d [NCH];
   logic [DIV_W-1:0] high_q   [NCH];
   logic [DIV_W-1:0] high_d   [NCH];
   logic [DIV_W-1:0] cnt_q    [NCH];
   logic [DIV_W-1:0] cnt_d    [NCH];
   chState_e         state_q  [NCH];
   chState_e         state_d  [NCH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            period_q[i] <= DIV_W'(DEF_DIV);
            high_q[i]   <= DIV_W'(DEF_DIV >> 1);
            cnt_q[i]    <= '0;
            state_q[i]  <= IDLE;
         end
      end else begin
         period_q <= period_d;
         high_q   <= high_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   // A load always wins over enable/sync so a reprogrammed channel restarts cleanly from IDLE.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         period_d[i] = period_q[i];
         high_d[i]   = high_q[i];
         cnt_d[i]    = cnt_q[i];
         state_d[i]  = state_q[i];

         if (load && (load_ch == CH_W'(i))) begin
            period_d[i] = div_val;
            high_d[i]   = high_val;
            cnt_d[i]    = '0;
            state_d[i]  = IDLE;
         end else if (!en[i] || (period_q[i] == '0)) begin
            cnt_d[i]    = '0;
            state_d[i]  = IDLE;
         end else if (state_q[i] == IDLE) begin
            cnt_d[i]    = '0;
            state_d[i]  = RUN;
         end else if (sync) begin
            cnt_d[i]    = '0;
         end else if (cnt_q[i] == (period_q[i] - DIV_W'(1))) begin
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i]    = cnt_q[i] + DIV_W'(1);
         end
      end
   end

   always_comb begin
      pout = '0;
      tick = '0;
      for (int i = 0; i < NCH; i++) begin
         pout[i] = (state_q[i] == RUN) && (cnt_q[i] < high_q[i]);
         tick[i] = (state_q[i] == RUN) && (cnt_q[i] == '0);
      end
   end

endmodule

// File: tb/tb_clk_pulse_gen.sv
// Directed self-checking bench for clk_pulse_gen: reset, load, edge periods, sync, enable priority and out-of-range load.
module tb_clk_pulse_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  en;
   logic        load;
   logic [1:0]  loadCh;
   logic [15:0] divVal;
   logic [15:0] highVal;
   logic        sync;
   logic [3:0]  pout;
   logic [3:0]  tick;

   logic [2:0]  en3;
   logic        load3;
   logic [1:0]  loadCh3;
   logic [15:0] divVal3;
   logic [15:0] highVal3;
   logic        sync3;
   logic [2:0]  pout3;
   logic [2:0]  tick3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_pulse_gen #(.NCH(4), .DIV_W(16), .DEF_DIV(10)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_ch(loadCh),
      .div_val(divVal), .high_val(highVal), .sync(sync), .pout(pout), .tick(tick)
   );

   clk_pulse_gen #(.NCH(3), .DIV_W(16), .DEF_DIV(10)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .load(load3), .load_ch(loadCh3),
      .div_val(divVal3), .high_val(highVal3), .sync(sync3), .pout(pout3), .tick(tick3)
   );

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns after the edge that produced them.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic doLoad(input logic [1:0] ch, input logic [15:0] p, input logic [15:0] h);
      load = 1'b1; loadCh = ch; divVal = p; highVal = h;
      applyStimulus();
      load = 1'b0;
   endtask

   logic [3:0] expTick;
   logic [3:0] expPout;

   initial begin
      rst_n = 1'b0; en = 4'hF; load = 1'b0; loadCh = '0; divVal = '0; highVal = '0; sync = 1'b0;
      en3 = 3'b111; load3 = 1'b0; loadCh3 = '0; divVal3 = '0; highVal3 = '0; sync3 = 1'b0;
      #2;

      // Reset held for three edges with all enables high
      for (int r = 0; r < 3; r++) begin
         applyStimulus();
         checkOutput("rst_pout", 16'(pout), 16'h0);
         checkOutput("rst_tick", 16'(tick), 16'h0);
      end

      // Default period 10, high 5; release edge is k=0
      rst_n = 1'b1;
      for (int k = 0; k < 23; k++) begin
         applyStimulus();
         checkOutput("def_tick", 16'(tick), ((k % 10) == 0) ? 16'hF : 16'h0);
         checkOutput("def_pout", 16'(pout), ((k % 10) < 5) ? 16'hF : 16'h0);
      end

      // Reset mid-period (counters at 2)
      rst_n = 1'b0;
      applyStimulus();
      checkOutput("midrst_pout", 16'(pout), 16'h0);
      checkOutput("midrst_tick", 16'(tick), 16'h0);
      rst_n = 1'b1;
      applyStimulus();
      checkOutput("rel_tick", 16'(tick), 16'hF);

      // Load ch1 P=4 H=1 on edge m=1; others keep the 10-cycle pattern
      doLoad(2'd1, 16'd4, 16'd1);
      checkOutput("ld_tick", 16'(tick), 16'h0);
      checkOutput("ld_pout", 16'(pout), 16'hD);
      for (int m = 2; m < 14; m++) begin
         applyStimulus();
         expTick = ((m % 10) == 0) ? 4'hD : 4'h0;
         expPout = ((m % 10) < 5)  ? 4'hD : 4'h0;
         expTick[1] = (((m - 2) % 4) == 0);
         expPout[1] = (((m - 2) % 4) == 0);
         checkOutput("ld_run_tick", 16'(tick), 16'(expTick));
         checkOutput("ld_run_pout", 16'(pout), 16'(expPout));
      end

      // Edge periods: ch0 P=1 H=1, ch1 P=0, ch2 P=5 H=0, ch3 P=5 H=7
      doLoad(2'd0, 16'd1, 16'd1);
      doLoad(2'd1, 16'd0, 16'd3);
      doLoad(2'd2, 16'd5, 16'd0);
      doLoad(2'd3, 16'd5, 16'd7);
      for (int n = 1; n <= 11; n++) begin
         applyStimulus();
         expTick = 4'h1;
         expPout = 4'h1;
         expTick[2] = ((n % 5) == 0);
         expTick[3] = (((n - 1) % 5) == 0);
         expPout[3] = 1'b1;
         checkOutput("edge_tick", 16'(tick), 16'(expTick));
         checkOutput("edge_pout", 16'(pout), 16'(expPout));
      end

      // Sync: ch0 and ch2 at P=6 with a 3-cycle offset (ch0 loaded S0, ch2 loaded S3)
      doLoad(2'd0, 16'd6, 16'd3);
      applyStimulus();
      applyStimulus();
      doLoad(2'd2, 16'd6, 16'd3);
      for (int j = 4; j <= 7; j++) begin
         applyStimulus();
         expTick = 4'h0;
         expTick[0] = (((j - 1) % 6) == 0);
         expTick[2] = (((j - 4) % 6) == 0);
         checkOutput("presync_tick", 16'(tick & 4'h5), 16'(expTick));
      end
      sync = 1'b1;
      applyStimulus();
      sync = 1'b0;
      checkOutput("sync_tick", 16'(tick & 4'h5), 16'h5);
      for (int j = 9; j <= 15; j++) begin
         applyStimulus();
         checkOutput("aligned_tick", 16'(tick & 4'h5), (((j - 8) % 6) == 0) ? 16'h5 : 16'h0);
      end

      // Enable drop and re-raise on ch3 (P=5 H=7, pout high while running)
      en[3] = 1'b0;
      applyStimulus();
      checkOutput("endrop_tick3", 16'(tick[3]), 16'h0);
      checkOutput("endrop_pout3", 16'(pout[3]), 16'h0);
      applyStimulus();
      en[3] = 1'b1;
      applyStimulus();
      checkOutput("reen_tick3", 16'(tick[3]), 16'h1);
      checkOutput("reen_pout3", 16'(pout[3]), 16'h1);
      applyStimulus();
      checkOutput("reen_c1_tick3", 16'(tick[3]), 16'h0);

      // Load ch3 and sync on the same edge: ch3 idles, ch0 still aligns
      sync = 1'b1;
      doLoad(2'd3, 16'd5, 16'd2);
      sync = 1'b0;
      checkOutput("ldsync_tick3", 16'(tick[3]), 16'h0);
      checkOutput("ldsync_pout3", 16'(pout[3]), 16'h0);
      checkOutput("ldsync_tick0", 16'(tick[0]), 16'h1);
      applyStimulus();
      checkOutput("ldsync_start3", 16'(tick[3]), 16'h1);

      // Out-of-range load on the 3-channel instance, held across a full period
      sync3 = 1'b1;
      applyStimulus();
      sync3 = 1'b0;
      checkOutput("oor_sync_tick", 16'(tick3), 16'h7);
      load3 = 1'b1; loadCh3 = 2'd3; divVal3 = 16'd2; highVal3 = 16'd1;
      for (int c = 1; c <= 11; c++) begin
         applyStimulus();
         checkOutput("oor_tick", 16'(tick3), ((c % 10) == 0) ? 16'h7 : 16'h0);
         checkOutput("oor_pout", 16'(pout3), ((c % 10) < 5) ? 16'h7 : 16'h0);
      end
      load3 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
